// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit engine with configurable width,
// parity and stop bits; one bit per clk, gap-free back-to-back frames.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stop2,
  output logic                  ready,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  stop2_q;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic                  stop_cnt;
  logic                  last_stop;
  logic                  accept;
  logic                  par_bit;

  assign last_stop = (state == STOP) && (stop_cnt == stop2_q);
  assign ready     = (state == IDLE) || last_stop;
  assign accept    = data_valid && ready;
  assign par_bit   = (^data_q) ^ par_typ_q;
  assign cnt_nxt   = cnt + 1'b1;

  // Capture word and frame format on every accepted handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else if (accept) begin
      data_q    <= p_data;
      par_en_q  <= par_en;
      par_typ_q <= par_typ;
      stop2_q   <= stop2;
    end
  end

  // Frame sequencer; tx_out and busy are set one state ahead
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      stop_cnt <= 1'b0;
      tx_out   <= 1'b1;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state  <= START;
            tx_out <= 1'b0;
            busy   <= 1'b1;
          end else begin
            tx_out <= 1'b1;
            busy   <= 1'b0;
          end
        end
        START: begin
          state  <= DATA;
          cnt    <= '0;
          tx_out <= data_q[0];
        end
        DATA: begin
          if (cnt == LAST) begin
            if (par_en_q) begin
              state  <= PARITY;
              tx_out <= par_bit;
            end else begin
              state    <= STOP;
              stop_cnt <= 1'b0;
              tx_out   <= 1'b1;
            end
          end else begin
            cnt    <= cnt_nxt;
            tx_out <= data_q[cnt_nxt];
          end
        end
        PARITY: begin
          state    <= STOP;
          stop_cnt <= 1'b0;
          tx_out   <= 1'b1;
        end
        STOP: begin
          if (last_stop) begin
            if (accept) begin
              state  <= START;
              tx_out <= 1'b0;
              busy   <= 1'b1;
            end else begin
              state  <= IDLE;
              tx_out <= 1'b1;
              busy   <= 1'b0;
            end
          end else begin
            stop_cnt <= 1'b1;
            tx_out   <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: random + directed frames checked by a
// bit-queue scoreboard against a frame-level reference model.
module tb_uart_tx_frame;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_en;
  logic          par_typ;
  logic          stop2;
  logic          ready;
  logic          tx_out;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int rem   = 0;
  bit exp_q[$];

  uart_tx_frame #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .stop2      (stop2),
    .ready      (ready),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act,
                       input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t",
               name, act, req, $time);
    end
  endtask

  function automatic void push_frame(input logic [DW-1:0] d,
                                     input bit pe, input bit pt,
                                     input bit s2);
    exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
    if (pe) exp_q.push_back((($countones(d) % 2) == 1) ^ pt);
    exp_q.push_back(1'b1);
    if (s2) exp_q.push_back(1'b1);
  endfunction

  // Reference model: rem = frame cycles still to go
  always @(posedge clk) begin
    if (rst) begin
      bit acc;
      acc = data_valid && (rem <= 1);
      if (rem > 0) rem--;
      if (acc) begin
        push_frame(p_data, par_en, par_typ, stop2);
        rem = 2 + DW + int'(par_en) + int'(stop2);
      end
    end
  end

  // Monitor: one expected line bit consumed per busy cycle
  always @(negedge clk) begin
    check("ready", ready, logic'(rem <= 1));
    if (exp_q.size() > 0) begin
      bit b;
      b = exp_q.pop_front();
      check("tx_bit", tx_out, b);
      check("busy_frame", busy, 1'b1);
    end else begin
      check("tx_idle", tx_out, 1'b1);
      check("busy_idle", busy, 1'b0);
    end
  end

  task automatic send(input logic [DW-1:0] d, input bit pe,
                      input bit pt, input bit s2);
    bit acc;
    int n;
    n = 0;
    @(negedge clk);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    stop2      = s2;
    data_valid = 1'b1;
    do begin
      acc = (rem <= 1);
      @(posedge clk);
      n++;
      if (!acc) @(negedge clk);
    end while (!acc && n < 200);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: word %h never accepted", d);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    data_valid = 1'b0;
    p_data     = DW'($urandom);
    repeat (n) @(posedge clk);
  endtask

  task automatic noise(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rem > 2) begin
        data_valid = 1'($urandom_range(0, 1));
        p_data     = DW'($urandom);
        par_typ    = 1'($urandom);
        par_en     = 1'($urandom);
        stop2      = 1'($urandom);
      end else begin
        data_valid = 1'b0;
      end
    end
    data_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst        = 1'b0;
    data_valid = 1'b0;
    p_data     = '0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    stop2      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    send(8'hA5, 1, 0, 0);
    idle(14);
    send(8'h00, 1, 1, 1);
    idle(14);
    send(8'h81, 0, 0, 0);
    idle(14);

    send(8'h55, 0, 0, 0);
    send(8'h33, 0, 0, 0);
    idle(24);

    send(8'hA5, 1, 0, 0);
    noise(14);
    idle(8);

    send(8'h96, 1, 1, 0);
    idle(0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    rem = 0;
    #1;
    check("mid_rst_tx", tx_out, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", ready, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    send(8'h3C, 0, 0, 0);
    idle(14);

    for (int k = 0; k < 40; k++) begin
      send(DW'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom));
      case ($urandom_range(0, 3))
        0: ;
        1: idle(int'($urandom_range(0, 3)));
        2: noise(6);
        default: idle(14);
      endcase
    end
    idle(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
